// File: rtl/bundle_acc.sv
// bundle_acc
// ----------
// Accumulates signed per-lane votes (+1 / 0 / -1) from the selector stage
// across the beats of a bundle, with one signed counter per lane. On the last
// beat it thresholds every counter into one bit, producing the majority
// hypervector. It then holds that result under a valid/ready handshake until
// the consumer takes it.
//
// Parameters:
//   LANES  - number of hypervector lanes (one 2-bit vote and one counter each)
//   ACC_W  - lane counter width, signed two's complement, >= 2
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   vote beat present
//   in_ready   out  beat accepted this cycle (high in ACCUM)
//   in_last    in   beat is the final one of the bundle
//   sel_bits   in   packed votes, lane i = sel_bits[2i+1:2i]
//                   (01 = +1, 11 = -1, 00 = 0, 10 = illegal, counted as 0)
//   out_valid  out  out_hv / out_count valid (high in HOLD)
//   out_ready  in   consumer takes the result
//   out_hv     out  majority hypervector, bit i = 1 iff counter i < 0
//   out_count  out  beats accepted in the bundle, saturating at 16'hFFFF
//   err        out  sticky flag, set when an illegal vote is accepted
//
// Build option:
//   BUNDLE_ACC_SAT_EN - when defined, lane counters saturate at their signed
//                       limits; otherwise they wrap modulo 2^ACC_W.

module bundle_acc #(
    parameter int LANES = 32,
    parameter int ACC_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [2*LANES-1:0]   sel_bits,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     out_hv,
    output logic [15:0]          out_count,
    output logic                 err
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        beat_q, beat_d;
    logic [LANES-1:0]   hv_q, hv_d;
    logic [15:0]        count_q, count_d;
    logic               err_q, err_d;

    logic               accept;
    logic               release_hold;
    logic [LANES-1:0]   illegal;
    logic [LANES-1:0]   sum_sign;

    // Handshake controls come from the state register only, so there is no
    // combinational path from out_ready to in_ready.
    assign accept       = in_valid  && (state_q == ACCUM);
    assign release_hold = out_ready && (state_q == HOLD);

    // ------------------------------------------------------------------
    // Per-lane counters
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [1:0]  vote;
            logic [ACC_W-1:0]   vote_ext;
            logic [ACC_W-1:0]   sum;
            logic [ACC_W-1:0]   acc_q, acc_d;

            assign vote       = sel_bits[2*gi +: 2];
            assign illegal[gi] = (vote == 2'b10);
            // Signed size cast sign-extends the vote; illegal code counts as 0.
            assign vote_ext   = illegal[gi] ? '0 : ACC_W'(vote);

`ifdef BUNDLE_ACC_SAT_EN
            logic [ACC_W:0] wide;
            assign wide = {acc_q[ACC_W-1], acc_q} + {vote_ext[ACC_W-1], vote_ext};
            // Overflow when the extra top bit disagrees with the result sign;
            // the extra bit then tells which limit was crossed.
            always_comb begin
                sum = wide[ACC_W-1:0];
                if (wide[ACC_W] != wide[ACC_W-1]) begin
                    sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
                end
            end
`else
            assign sum = acc_q + vote_ext;
`endif

            assign sum_sign[gi] = sum[ACC_W-1];

            always_comb begin
                acc_d = acc_q;
                if (accept) begin
                    acc_d = sum;
                end else if (release_hold) begin
                    acc_d = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM, beat counter, result registers
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        hv_d    = hv_q;
        count_d = count_q;
        err_d   = err_q | (accept && (|illegal));
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    beat_d = (beat_q == 16'hFFFF) ? beat_q : beat_q + 16'd1;
                    if (in_last) begin
                        // Threshold on the counters including this beat.
                        hv_d    = sum_sign;
                        count_d = beat_d;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    beat_d  = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            beat_q  <= '0;
            hv_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            hv_q    <= hv_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_hv    = hv_q;
    assign out_count = count_q;
    assign err       = err_q;

endmodule

// File: doc/bundle_acc.md
# bundle_acc

Downstream of the per-lane `selector` stage: accumulates the signed ±1/0 votes it emits across a stream of beats into one signed counter per hypervector lane. On the last beat of a bundle it thresholds every counter into one output bit, giving the majority hypervector. It then holds that result under a valid/ready handshake until the consumer (store/writeback) takes it.

## Interface
- `LANES`, 32, number of hypervector lanes; one 2-bit vote and one counter per lane.
- `ACC_W`, 8, counter width in bits, signed two's complement, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: vote beat present.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_last` in 1: qualifies the beat as the final one of the current bundle.
- `sel_bits` in 2*LANES: packed votes; lane i is `sel_bits[2i+1:2i]`, signed 2-bit: 01 = +1, 11 = −1, 00 = 0, 10 = illegal.
- `out_valid` out 1: `out_hv` and `out_count` valid.
- `out_ready` in 1: consumer takes the result.
- `out_hv` out LANES: majority hypervector; bit i = 1 iff counter i < 0.
- `out_count` out 16: number of beats accepted in the bundle, saturating at 16'hFFFF.
- `err` out 1: sticky; set when an illegal vote is accepted; cleared only by reset.

## Operation
- Two states: ACCUM (reset state) and HOLD.
- ACCUM:
  - `in_ready` = 1.
  - On `in_valid`, each lane counter is updated as acc[i] <= acc[i] + vote[i], and the beat counter increments.
  - A vote of 10 is treated as 0 and sets `err`.
- ACCUM, accepted beat with `in_last` = 1:
  - The final beat's votes are included before thresholding.
  - `out_hv[i]` is registered from the sign bit of the updated acc[i].
  - `out_count` is registered from the updated beat count.
  - FSM moves to HOLD.
- HOLD:
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_hv` and `out_count` stay stable until `out_ready`.
  - On `out_ready`, all lane counters and the beat counter clear to 0 and the FSM returns to ACCUM.
- Tie (acc == 0) gives `out_hv` bit 0. This matches the selector encoding, where +1 votes for bit 0 and −1 votes for bit 1.
- Counter arithmetic is sign-extended: the 2-bit vote is extended to ACC_W. Overflow behaviour is set by Configuration.
- Beat counter saturates at 16'hFFFF; it never wraps.

## Timing
- Reset values (asynchronous):
  - `in_ready` = 1, `out_valid` = 0, `out_hv` = 0, `out_count` = 0, `err` = 0.
  - All counters 0, state ACCUM.
- `in_ready` and `out_valid` are decoded from the state register only; no combinational path from `out_ready` to `in_ready`.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted.
- Handshake:
  - Throughput is one beat per cycle in ACCUM.
  - The handover costs one bubble: after the `out_ready` cycle, the next beat is accepted the following cycle, at the earliest.
- `out_ready` while in ACCUM is ignored.
- `in_valid` while in HOLD is not accepted; upstream must hold its beat.
- Single-beat bundle (`in_last` on the first beat): the result equals that beat's votes thresholded; `out_count` = 1.
- Reset asserted mid-bundle or in HOLD: everything returns to reset values immediately; the partial bundle is discarded.

## Configuration
- `BUNDLE_ACC_SAT_EN` defined: lane counters saturate at +(2^(ACC_W−1)−1) and −2^(ACC_W−1). A vote pushing past either limit leaves the counter at the limit.
- Not defined: lane counters wrap modulo 2^ACC_W. The sign, and hence `out_hv`, may flip on overflow; this is the caller's responsibility to avoid by bounding the bundle length.

## Test plan
- Reset then three beats, all lanes 01,01,11 (`in_last` on third) → `out_valid` next cycle, `out_hv` = 32'h0, `out_count` = 3.
- Lane 0 votes 11,11,01, other lanes 00 → `out_hv` = 32'h1, `out_count` = 3. Lane 5 votes 01 then 11 (tie) → `out_hv[5]` = 0.
- HOLD with `out_ready` = 0 for 4 cycles while `in_valid` = 1 → `in_ready` stays 0 and outputs stay stable. Then `out_ready` = 1 → the next cycle is ACCUM with counters 0, and the next bundle starts clean.
- 200 beats of 11 on lane 0, `ACC_W` = 8:
  - With `BUNDLE_ACC_SAT_EN`: counter stops at −128 and `out_hv[0]` = 1.
  - Without it: counter wraps to +56 and `out_hv[0]` = 0.
- Beat containing vote 10 on lane 3 → that lane is unchanged and `err` = 1, remaining set through later bundles until `rst_n` low.
- `rst_n` pulsed low mid-bundle after 2 beats → outputs return to reset values at once. A following single `in_last` beat of all 11 gives `out_hv` = 32'hFFFFFFFF, `out_count` = 1.
